ysyx_041514_mem_access_ctrl: RTL
================================

// Module: ysyx_041514_mem_access_ctrl
// PURPOSE
//  Sequencer for the MEM-stage dcache/fence.i port. Tracks each outstanding access and latches the
//  one-cycle dcache response (load data / store ack / fence.i done) while MEM is held by a younger stall.
//  Drives rdata_buff_* and mem_fencei_buff_* back into the MEM stage, preventing re-issue and data loss.
//  Drains accesses orphaned by a pipeline flush. Raises a sticky watchdog on a hung port.
// PARAMETERS
//  TIMEOUT_CYCLES  1024  cycles in WAIT/FWAIT/DRAIN before timeout_o sets; 0 disables the watchdog
//  CNT_W           11    watchdog counter width; must hold TIMEOUT_CYCLES
// PORTS
//  clk                      in   1     core clock
//  rst                      in   1     synchronous reset, active high
//  mem_access_i             in   1     MEM holds a load or store (isload|isstore)
//  mem_fencei_i             in   1     MEM holds fence.i
//  mem_addr_valid_i         in   1     MEM is requesting the dcache this cycle
//  mem_fencei_valid_i       in   1     MEM is requesting a dcache flush this cycle
//  mem_data_ready_i         in   1     dcache read/write-done pulse
//  mem_fencei_ready_i       in   1     dcache flush-done pulse
//  mem_data_i               in   64    MEM formatted load result (sign/zero-extended)
//  stall_i                  in   1     MEM/WB will not advance this cycle (excludes MEM's own stall)
//  flush_i                  in   1     MEM instruction is squashed (trap/redirect)
//  rdata_buff_valid_o       out  1     buffered response valid; MEM uses rdata_buff_o, must not re-issue
//  rdata_buff_o             out  64    buffered load result
//  mem_fencei_buff_valid_o  out  1     fence.i completion buffered
//  mem_fencei_ready_buff_o  out  1     buffered fence.i ready (1 whenever buff_valid)
//  req_block_o              out  1     gate for new dcache requests (DRAIN/FDRAIN)
//  timeout_o                out  1     sticky watchdog flag
// BEHAVIOUR
//  All outputs 0 on reset; state IDLE; counter 0; rdata_buff_o 0.
//  States: IDLE, WAIT, HOLD, FWAIT, FHOLD, DRAIN, FDRAIN (3-bit encoding).
//  Priority per cycle: rst > flush_i > ready pulse > request.
//  IDLE: mem_access_i&mem_data_ready_i&stall_i&~flush_i -> HOLD, capture mem_data_i;
//        mem_addr_valid_i&~mem_data_ready_i -> WAIT; fencei analogues -> FHOLD / FWAIT.
//  WAIT: ready&stall_i&~flush_i -> HOLD (capture); ready&~stall_i -> IDLE (pass-through, no buffer);
//        flush_i&~ready -> DRAIN; flush_i&ready -> IDLE, data discarded.
//  HOLD: rdata_buff_valid_o=1; ~stall_i (instr advances) or flush_i -> IDLE next cycle.
//        The buffer is stable for the whole of HOLD; a ready pulse in HOLD is ignored.
//  FWAIT/FHOLD mirror WAIT/HOLD on mem_fencei_ready_i; buffer outputs are fencei_buff_valid/ready_buff.
//  DRAIN/FDRAIN: req_block_o=1; leave to IDLE on the matching ready pulse. The response is dropped.
//  Stores use HOLD like loads: rdata_buff_valid_o marks the write done, so MEM must not rewrite.
//  Latency: buffer outputs rise the cycle after the capturing ready pulse; they fall the cycle after release.
//  Watchdog: counter increments in WAIT/FWAIT/DRAIN/FDRAIN, saturates, clears on any other state.
//    timeout_o sets when counter==TIMEOUT_CYCLES-1 and the state is still waiting; it clears only on rst.
//  Simultaneous ready+flush in WAIT: no buffer; IDLE; no drain.
//  A clint access never reaches the dcache (mem_addr_valid_i=0, no ready); the FSM stays IDLE.
//  rst in any state: IDLE next cycle; the dcache is reset by the same rst, so there is no drain.
// STRUCTURE
//  sysconfig.v: `ysyx_041514_MEMCTL_IDLE..FDRAIN state macros and `ysyx_041514_MEMCTL_TIMEOUT default.
//  One sub-module: ysyx_041514_sat_counter (CNT_W, inc/clr, saturates, reusable by the icache watchdog).
//  Everything else (one FSM always block and a 64-bit data register) stays in this file.
// TESTING
//  1. Load, ready on cycle 3, stall_i=0 -> no buffer, state IDLE, rdata_buff_valid_o stays 0.
//  2. Load, ready with stall_i=1 for 4 cycles, mem_data_i=64'hFFFF_FFFF_FFFF_FF80 -> buff_valid 1 for 4 cycles,
//     value stable, 0 the cycle after stall_i drops.
//  3. Store in WAIT, flush_i at cycle 2, ready at cycle 6 -> DRAIN cycles 3-6, req_block_o=1, IDLE at 7, no buffer.
//  4. fence.i, mem_fencei_ready_i with stall_i=1 -> fencei_buff_valid/ready_buff=1 until release.
//  5. TIMEOUT_CYCLES=8, ready never arrives -> timeout_o=1 on the 8th WAIT cycle; it stays set until rst.
//  6. rst asserted in HOLD -> every output 0 the next cycle, state IDLE.

Source files
------------

// File: rtl/ysyx_041514_mem_access_ctrl_pkg.sv
// Shared types and defaults for the MEM-stage dcache/fence.i access sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ysyx_041514_mem_access_ctrl_pkg;

  // Sequencer states. WAIT/HOLD handle loads/stores, FWAIT/FHOLD handle fence.i,
  // DRAIN/FDRAIN swallow a response whose requester was squashed.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WAIT   = 3'd1,
    ST_HOLD   = 3'd2,
    ST_FWAIT  = 3'd3,
    ST_FHOLD  = 3'd4,
    ST_DRAIN  = 3'd5,
    ST_FDRAIN = 3'd6
  } memctl_state_t;

  localparam int MEMCTL_TIMEOUT = 1024;

  // States in which the port owes us a response; the watchdog runs only here.
  function automatic logic is_waiting(memctl_state_t s);
    return (s == ST_WAIT) || (s == ST_FWAIT) || (s == ST_DRAIN) || (s == ST_FDRAIN);
  endfunction

endpackage

// File: rtl/ysyx_041514_mem_access_ctrl_if.sv
// MEM-stage <-> access sequencer signal bundle.
// Latency: n/a (wires only).
// Backpressure: stall_i holds a captured response in the buffer; req_block_o gates new requests.
// master: MEM stage / dcache side (drives requests, ready pulses, stall/flush).
// slave : the sequencer (drives the rdata/fence.i buffers, req_block_o, timeout_o).
interface ysyx_041514_mem_access_ctrl_if;
  logic        mem_access_i;
  logic        mem_fencei_i;
  logic        mem_addr_valid_i;
  logic        mem_fencei_valid_i;
  logic        mem_data_ready_i;
  logic        mem_fencei_ready_i;
  logic [63:0] mem_data_i;
  logic        stall_i;
  logic        flush_i;
  logic        rdata_buff_valid_o;
  logic [63:0] rdata_buff_o;
  logic        mem_fencei_buff_valid_o;
  logic        mem_fencei_ready_buff_o;
  logic        req_block_o;
  logic        timeout_o;

  modport master (
    output mem_access_i, mem_fencei_i, mem_addr_valid_i, mem_fencei_valid_i,
           mem_data_ready_i, mem_fencei_ready_i, mem_data_i, stall_i, flush_i,
    input  rdata_buff_valid_o, rdata_buff_o, mem_fencei_buff_valid_o,
           mem_fencei_ready_buff_o, req_block_o, timeout_o
  );

  modport slave (
    input  mem_access_i, mem_fencei_i, mem_addr_valid_i, mem_fencei_valid_i,
           mem_data_ready_i, mem_fencei_ready_i, mem_data_i, stall_i, flush_i,
    output rdata_buff_valid_o, rdata_buff_o, mem_fencei_buff_valid_o,
           mem_fencei_ready_buff_o, req_block_o, timeout_o
  );
endinterface

// File: rtl/ysyx_041514_sat_counter.sv
// Saturating up-counter with synchronous clear, shared by the cache-port watchdogs.
// Latency: cnt updates one cycle after inc/clr; cnt_nxt is the combinational next value.
// Backpressure: none; holds at all-ones instead of wrapping.
// Ports: clk, rst (sync, active high), inc, clr (clr wins), cnt, cnt_nxt.
module ysyx_041514_sat_counter #(
  parameter int CNT_W = 11
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt,
  output logic [CNT_W-1:0] cnt_nxt
);

  always_comb begin
    cnt_nxt = cnt;
    if (clr) begin
      cnt_nxt = '0;
    end else if (inc && (cnt != '1)) begin
      cnt_nxt = cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else begin
      cnt <= cnt_nxt;
    end
  end

endmodule

// File: rtl/ysyx_041514_mem_access_ctrl.sv
// MEM-stage dcache/fence.i sequencer: latches one-cycle responses while MEM is stalled, drains squashed accesses.
// Latency: buffer/req_block outputs are registered -- they change the cycle after the triggering input.
// Backpressure: stall_i keeps a captured response in HOLD/FHOLD; req_block_o stops new requests while draining.
// Ports: clk, rst (sync, active high), bus (slave modport: MEM request/ready/stall/flush in, buffers out).
module ysyx_041514_mem_access_ctrl
  import ysyx_041514_mem_access_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = MEMCTL_TIMEOUT,
  parameter int CNT_W          = 11
) (
  input logic                       clk,
  input logic                       rst,
  ysyx_041514_mem_access_ctrl_if.slave bus
);

  // Value the counter holds on the TIMEOUT_CYCLES-th consecutive waiting cycle.
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  memctl_state_t    state;
  memctl_state_t    state_nxt;
  logic             capture;
  logic [CNT_W-1:0] wd_cnt;
  logic [CNT_W-1:0] wd_cnt_nxt;

  ysyx_041514_sat_counter #(.CNT_W(CNT_W)) u_wd (
    .clk     (clk),
    .rst     (rst),
    .inc     (is_waiting(state)),
    .clr     (!is_waiting(state)),
    .cnt     (wd_cnt),
    .cnt_nxt (wd_cnt_nxt)
  );

  // Next state: flush beats a ready pulse, which beats a new request.
  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    case (state)
      ST_IDLE: begin
        // A flushed instruction's request is treated as never issued.
        if (!bus.flush_i) begin
          if (bus.mem_access_i && bus.mem_data_ready_i) begin
            // Same-cycle hit: only buffer it if MEM cannot consume it now.
            if (bus.stall_i) begin
              state_nxt = ST_HOLD;
              capture   = 1'b1;
            end
          end else if (bus.mem_addr_valid_i && !bus.mem_data_ready_i) begin
            state_nxt = ST_WAIT;
          end else if (bus.mem_fencei_i && bus.mem_fencei_ready_i) begin
            if (bus.stall_i) state_nxt = ST_FHOLD;
          end else if (bus.mem_fencei_valid_i && !bus.mem_fencei_ready_i) begin
            state_nxt = ST_FWAIT;
          end
        end
      end
      ST_WAIT: begin
        if (bus.flush_i) begin
          // Response arriving with the flush is simply dropped; otherwise it is still owed.
          state_nxt = bus.mem_data_ready_i ? ST_IDLE : ST_DRAIN;
        end else if (bus.mem_data_ready_i) begin
          if (bus.stall_i) begin
            state_nxt = ST_HOLD;
            capture   = 1'b1;
          end else begin
            state_nxt = ST_IDLE;
          end
        end
      end
      ST_HOLD: begin
        if (bus.flush_i || !bus.stall_i) state_nxt = ST_IDLE;
      end
      ST_FWAIT: begin
        if (bus.flush_i) begin
          state_nxt = bus.mem_fencei_ready_i ? ST_IDLE : ST_FDRAIN;
        end else if (bus.mem_fencei_ready_i) begin
          state_nxt = bus.stall_i ? ST_FHOLD : ST_IDLE;
        end
      end
      ST_FHOLD: begin
        if (bus.flush_i || !bus.stall_i) state_nxt = ST_IDLE;
      end
      ST_DRAIN: begin
        if (bus.mem_data_ready_i) state_nxt = ST_IDLE;
      end
      ST_FDRAIN: begin
        if (bus.mem_fencei_ready_i) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State plus registered outputs, all decoded from the next state so they
  // line up with the state they describe.
  always_ff @(posedge clk) begin
    if (rst) begin
      state                       <= ST_IDLE;
      bus.rdata_buff_valid_o      <= 1'b0;
      bus.rdata_buff_o            <= '0;
      bus.mem_fencei_buff_valid_o <= 1'b0;
      bus.mem_fencei_ready_buff_o <= 1'b0;
      bus.req_block_o             <= 1'b0;
      bus.timeout_o               <= 1'b0;
    end else begin
      state                       <= state_nxt;
      bus.rdata_buff_valid_o      <= (state_nxt == ST_HOLD);
      bus.mem_fencei_buff_valid_o <= (state_nxt == ST_FHOLD);
      bus.mem_fencei_ready_buff_o <= (state_nxt == ST_FHOLD);
      bus.req_block_o             <= (state_nxt == ST_DRAIN) || (state_nxt == ST_FDRAIN);
      if (capture) begin
        bus.rdata_buff_o <= bus.mem_data_i;
      end
      // Sticky: only rst clears it, so a hang stays visible to debug.
      if ((TIMEOUT_CYCLES != 0) && is_waiting(state_nxt) && (wd_cnt_nxt == TO_LAST)) begin
        bus.timeout_o <= 1'b1;
      end
    end
  end

endmodule
